// File: rtl/iter_div_pkg.sv
// iter_div_pkg: shared FSM state type and counter sizing for the iterative ceiled divider.
package iter_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} iter_div_state_e;
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/iter_ceil_div_if.sv
// iter_ceil_div_if: operand/result valid-ready handshake bundle of the iterative divider.
interface iter_ceil_div_if #(parameter int WIDTH = 32);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             ceil_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;
  modport master (
    output in_valid_i, dividend_i, divisor_i, ceil_i, out_ready_i,
    input  in_ready_o, out_valid_o, quotient_o, remainder_o, div_zero_o
  );
  modport slave (
    input  in_valid_i, dividend_i, divisor_i, ceil_i, out_ready_i,
    output in_ready_o, out_valid_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/iter_div_step.sv
// iter_div_step: one combinational restoring-division step (shift in a dividend bit, conditionally subtract).
module iter_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, diff;
  // rem < divisor always holds, so the sign of the (WIDTH+1)-bit difference is exact
  always_comb begin
    shifted = {rem, din};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/iter_ceil_div.sv
// iter_ceil_div: radix-2 restoring unsigned divider with per-operation ceil/floor quotient.
// ITER_CEIL_DIV_EARLY_OUT_EN: finish in one cycle when dividend < divisor.
module iter_ceil_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  iter_ceil_div_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  iter_div_state_e  state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, rem, dsr, rem_nxt;
  logic             ceil_r, dz, q_bit, early, div0;
  iter_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .din     (acc[WIDTH-1]),
    .divisor (dsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );
  always_comb begin
    div0 = bus.divisor_i == '0;
`ifdef ITER_CEIL_DIV_EARLY_OUT_EN
    early = bus.dividend_i < bus.divisor_i;
`else
    early = 1'b0;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !bus.in_valid_i ? IDLE : (div0 || early) ? DONE : CALC;
      CALC:    state_nxt = (cnt == '0) ? FIX : CALC;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = bus.out_ready_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready_o  = state == IDLE;
    bus.out_valid_o = state == DONE;
    bus.quotient_o  = acc;
    bus.remainder_o = rem;
    bus.div_zero_o  = dz;
  end
  // acc holds the unconsumed dividend bits above the quotient bits shifted in so far
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      dsr    <= '0;
      ceil_r <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid_i) begin
          dsr    <= bus.divisor_i;
          ceil_r <= bus.ceil_i;
          cnt    <= CW'(WIDTH - 1);
          dz     <= div0;
          acc    <= div0 ? '1 : early ? WIDTH'(bus.ceil_i && bus.dividend_i != '0) : bus.dividend_i;
          rem    <= (div0 || early) ? bus.dividend_i : '0;
        end
        CALC: begin
          acc <= {acc[WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: if (ceil_r && rem != '0) acc <= acc + WIDTH'(1);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_iter_ceil_div.sv
// tb_iter_ceil_div: directed scoreboard bench for iter_ceil_div (latency model follows ITER_CEIL_DIV_EARLY_OUT_EN).
module tb_iter_ceil_div;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  iter_ceil_div_if #(.WIDTH(W)) bus ();
  iter_ceil_div #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int n = 0;
    logic [63:0] a64, b64;
    a64 = 64'(a);
    b64 = 64'(b);
    @(negedge clk);
    while (!bus.in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(bus.in_ready_o), 64'd1);
    bus.in_valid_i = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.ceil_i     = c;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      e.q = W'(c ? (a64 + b64 - 64'd1) / b64 : a64 / b64);
      e.r = W'(a64 % b64);
      e.dz = 1'b0;
      e.lat = W + 2;
`ifdef ITER_CEIL_DIV_EARLY_OUT_EN
      if (a < b) e.lat = 1;
`endif
    end
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int n = 1;
    while (!bus.out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(n), 64'(e.lat));
    check({tag, "_q"}, 64'(bus.quotient_o), 64'(e.q));
    check({tag, "_r"}, 64'(bus.remainder_o), 64'(e.r));
    check({tag, "_dz"}, 64'(bus.div_zero_o), 64'(e.dz));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid_i = 1'b1;
      bus.dividend_i = 32'd9;
      bus.divisor_i  = 32'd3;
      @(negedge clk);
      check({tag, "_hold_q"}, 64'(bus.quotient_o), 64'(e.q));
      check({tag, "_hold_r"}, 64'(bus.remainder_o), 64'(e.r));
      check({tag, "_hold_rdy"}, 64'(bus.in_ready_o), 64'd0);
      check({tag, "_hold_vld"}, 64'(bus.out_valid_o), 64'd1);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    check({tag, "_post_rdy"}, 64'(bus.in_ready_o), 64'd1);
    check({tag, "_post_vld"}, 64'(bus.out_valid_o), 64'd0);
    if (hold > 0) begin
      @(negedge clk);
      check({tag, "_no_stray"}, 64'(bus.out_valid_o), 64'd0);
    end
  endtask
  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    issue(tag, a, b, c);
    collect(tag, 0);
  endtask
  initial begin
    bus.in_valid_i  = 1'b0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.ceil_i      = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_q", 64'(bus.quotient_o), 64'd0);
    check("rst_r", 64'(bus.remainder_o), 64'd0);
    check("rst_dz", 64'(bus.div_zero_o), 64'd0);
    rst_n = 1'b1;
    run("100_7_ceil", 32'd100, 32'd7, 1'b1);
    check("100_7_ceil_q_const", 64'(bus.quotient_o), 64'd15);
    run("100_7_floor", 32'd100, 32'd7, 1'b0);
    check("100_7_floor_q_const", 64'(bus.quotient_o), 64'd14);
    run("42_6_ceil", 32'd42, 32'd6, 1'b1);
    run("5_0", 32'd5, 32'd0, 1'b1);
    run("max_1_ceil", 32'hFFFF_FFFF, 32'd1, 1'b1);
    run("max_2_ceil", 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("max_2_q_const", 64'(bus.quotient_o), 64'h8000_0000);
    run("3_10_ceil", 32'd3, 32'd10, 1'b1);
    run("3_10_floor", 32'd3, 32'd10, 1'b0);
    run("0_5_ceil", 32'd0, 32'd5, 1'b1);
    run("max_max_ceil", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
      run($sformatf("rand%0d", i), a, b, 1'(i % 3 == 0));
    end
    issue("bp", 32'd100, 32'd7, 1'b1);
    collect("bp", 10);
    issue("abort", 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rdy", 64'(bus.in_ready_o), 64'd1);
    check("abort_vld", 64'(bus.out_valid_o), 64'd0);
    check("abort_q", 64'(bus.quotient_o), 64'd0);
    check("abort_r", 64'(bus.remainder_o), 64'd0);
    check("abort_dz", 64'(bus.div_zero_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    repeat (W + 5) @(negedge clk);
    check("abort_no_result", 64'(bus.out_valid_o), 64'd0);
    run("recover", 32'd77, 32'd5, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iter_ceil_div.md
# iter_ceil_div

Sequential radix-2 restoring divider for natural (unsigned) operands, one quotient bit per cycle, with per-operation selection of round-toward-plus-infinity (ceiled) or truncating (floored) quotient. Runtime counterpart of the elaboration-time ceiled-division constant function in the shared math package. Used by datapath blocks that compute burst counts, beat counts and buffer-fill figures from run-time lengths. Valid/ready handshake on both sides; one operation in flight.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width; legal range ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: operands valid.
- `in_ready_o` out 1: block idle and accepting.
- `dividend_i` in WIDTH: unsigned dividend.
- `divisor_i` in WIDTH: unsigned divisor.
- `ceil_i` in 1: 1 = ceiled quotient, 0 = floored quotient.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `quotient_o` out WIDTH: quotient per `ceil_i` captured at acceptance.
- `remainder_o` out WIDTH: floor remainder, `dividend - floor(dividend/divisor)*divisor`, in both modes.
- `div_zero_o` out 1: divisor was zero; qualified by `out_valid_o`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: `in_ready_o`=1. On `in_valid_i`: latch operands and `ceil_i`; counter = WIDTH-1; partial remainder = 0. Divisor ≠ 0 → CALC; divisor = 0 → DONE with quotient all-ones, remainder = dividend, `div_zero_o`=1.
- CALC: per cycle shift partial remainder left by one, take next dividend MSB, subtract divisor if result non-negative, shift quotient bit in. Counter 0 → FIX; otherwise decrement.
- FIX: if ceil mode and remainder ≠ 0, quotient += 1; → DONE. No overflow possible: non-zero remainder implies divisor ≥ 2, so quotient ≤ (2^WIDTH-1)/2.
- DONE: `out_valid_o`=1, outputs stable. On `out_ready_i` → IDLE.
- `in_ready_o` is 0 in CALC, FIX and DONE; inputs there are ignored.
- Reset at any point (including mid-CALC) aborts the operation: IDLE, all outputs 0, no result emitted.
- Output registers; no combinational path from any input to any output.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `quotient_o`=0, `remainder_o`=0, `div_zero_o`=0.
- Acceptance edge = cycle 0. Normal latency: CALC cycles 1..WIDTH, FIX cycle WIDTH+1, `out_valid_o` high from cycle WIDTH+2.
- Divide-by-zero: `out_valid_o` high in cycle 1.
- Result held indefinitely under back-pressure. After the output handshake edge, `in_ready_o`=1 the next cycle. Minimum issue interval is WIDTH+3 cycles.

## Configuration
- `ITER_CEIL_DIV_EARLY_OUT_EN` defined: in IDLE, a non-zero divisor with dividend < divisor (including dividend 0) goes directly to DONE. Quotient is 0 in floor mode, or (dividend ≠ 0 ? 1 : 0) in ceil mode; remainder = dividend. Latency 1.
- Not defined: all non-zero-divisor operations take the full WIDTH+2 cycles. Results are bit-identical either way.

## Structure
- New package `iter_div_pkg`: FSM state enum `iter_div_state_e` and function `cnt_width(WIDTH)`. `cnt_width` returns the clog2-based counter width, with a minimum of 1.
- One sub-module, `iter_div_step`: purely combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor. Outputs are next partial remainder and quotient bit.

## Test plan
- WIDTH=32, 100/7 ceil → q=15, r=2 at cycle 34; same operands floor → q=14, r=2.
- 42/6 ceil → q=7, r=0; no increment applied in FIX.
- 5/0 → `div_zero_o`=1, q=0xFFFFFFFF, r=5, `out_valid_o` in cycle 1.
- 0xFFFFFFFF/1 ceil → q=0xFFFFFFFF, r=0. 0xFFFFFFFF/2 ceil → q=0x80000000, r=1.
- `out_ready_i` held low 10 cycles in DONE → outputs stable, `in_ready_o`=0, and new `in_valid_i` ignored. Repeat with `rst_ni` pulsed in cycle 10 of CALC → IDLE, all outputs 0.
- 3/10 ceil, with and without `ITER_CEIL_DIV_EARLY_OUT_EN` → q=1, r=3 in both builds. Latency is 1 with the macro and 34 without.
